// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the elastic register pipeline.
//   PIPE_WIDTH / PIPE_DEPTH : default payload width and stage count
//   occ_width(depth)        : bits needed to count 0..depth valid stages
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;
  localparam int PIPE_DEPTH = 3;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// elastic_stage: one valid/data register of the elastic pipeline.
//   i_clk, i_rst_n : clock, async active-low reset (clears valid and data)
//   i_load         : stage ready this cycle, take the upstream beat/bubble
//   i_flush        : drop the held beat at the next edge (beats any load)
//   i_vld, i_data  : upstream valid/payload
//   o_vld, o_data  : held valid/payload
module elastic_stage #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_vld <= 1'b0;
    else if (i_flush) r_vld <= 1'b0;
    else if (i_load)  r_vld <= i_vld;
  end

  // Data only captured on a real beat so bubbles do not toggle the payload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             r_data <= '0;
    else if (i_load && i_vld) r_data <= i_data;
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready register pipeline with full
// backpressure, synchronous flush and an occupancy count.
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_in_valid, i_in_data    : upstream beat
//   o_in_ready               : beat accepted this cycle
//   o_out_valid, o_out_data  : last-stage beat
//   i_out_ready              : downstream accepts this cycle
//   i_flush                  : discard all held beats at the next edge
//   o_occupancy              : number of valid stages (registered)
// Macro ELASTIC_PIPELINE_OCC_EN: when defined the occupancy register is
// built; otherwise o_occupancy is tied to 0.
module elastic_pipeline
  import pipe_pkg::*;
#(
  parameter  int WIDTH = PIPE_WIDTH,
  parameter  int DEPTH = PIPE_DEPTH,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ready,
  input  logic             i_flush,
  output logic [OCC_W-1:0] o_occupancy
);

  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0]            w_rdy;
  logic [DEPTH-1:0]            w_src_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_d;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_d;

  // Ready ripples back from the sink: a stage may load if it is empty or
  // its successor is loading, so a full pipe advances without a bubble.
  always_comb begin
    logic r;
    r = !w_v[DEPTH-1] | i_out_ready;
    w_rdy = '0;
    w_rdy[DEPTH-1] = r;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      r = !w_v[k] | r;
      w_rdy[k] = r;
    end
  end

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_src_v[k] = i_in_valid & !i_flush;
        assign w_src_d[k] = i_in_data;
      end else begin : g_body
        assign w_src_v[k] = w_v[k-1];
        assign w_src_d[k] = w_d[k-1];
      end

      elastic_stage #(.WIDTH(WIDTH)) u_stage (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_rdy[k]),
        .i_flush (i_flush),
        .i_vld   (w_src_v[k]),
        .i_data  (w_src_d[k]),
        .o_vld   (w_v[k]),
        .o_data  (w_d[k])
      );
    end
  endgenerate

  assign o_in_ready  = w_rdy[0] & !i_flush;
  assign o_out_valid = w_v[DEPTH-1];
  assign o_out_data  = w_d[DEPTH-1];

`ifdef ELASTIC_PIPELINE_OCC_EN
  logic [DEPTH-1:0] w_v_nxt;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [OCC_W-1:0] r_occ;

  // Mirror the stage update so the count lands on the same edge as v.
  always_comb begin
    w_v_nxt   = '0;
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_v_nxt[i] = i_flush ? 1'b0 : (w_rdy[i] ? w_src_v[i] : w_v[i]);
      w_occ_nxt  = w_occ_nxt + OCC_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_occ <= '0;
    else          r_occ <= w_occ_nxt;
  end

  assign o_occupancy = r_occ;
`else
  assign o_occupancy = '0;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
module tb_elastic_pipeline;

`ifdef ELASTIC_PIPELINE_OCC_EN
  localparam int OCC_ON = 1;
`else
  localparam int OCC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // DEPTH=3, WIDTH=32 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  // DEPTH=1, WIDTH=8 instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [7:0]  s_in_data, s_out_data;
  logic [0:0]  s_occ;

  elastic_pipeline #(.WIDTH(32), .DEPTH(3)) u_big (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(b_in_valid), .i_in_data(b_in_data), .o_in_ready(b_in_ready),
    .o_out_valid(b_out_valid), .o_out_data(b_out_data), .i_out_ready(b_out_ready),
    .i_flush(b_flush), .o_occupancy(b_occ)
  );

  elastic_pipeline #(.WIDTH(8), .DEPTH(1)) u_small (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(s_in_valid), .i_in_data(s_in_data), .o_in_ready(s_in_ready),
    .o_out_valid(s_out_valid), .o_out_data(s_out_data), .i_out_ready(s_out_ready),
    .i_flush(s_flush), .o_occupancy(s_occ)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rcv[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  initial begin
    int sent, first_acc, first_out, last_out, max_occ, cyc;
    logic [7:0] s_max_occ;

    // ---- reset state and idle hold
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_out_data",  64'(b_out_data),  64'd0);
    chk("rst_occ",       64'(b_occ),       64'd0);
    chk("rst_in_ready",  64'(b_in_ready),  64'd1);
    step();
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_hold", {b_out_valid, b_out_data, 2'(b_occ), b_in_ready},
          {1'b0, 32'd0, 2'd0, 1'b1});
    end

    // ---- stream 1..8, out_ready high
    do_reset();
    sent = 0; first_acc = -1; first_out = -1; last_out = -1; max_occ = 0;
    rcv.delete();
    b_out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      b_in_valid = (sent < 8);
      b_in_data  = 32'(sent + 1);
      #1;
      if (b_out_valid && b_out_ready) begin
        rcv.push_back(b_out_data);
        if (first_out < 0) first_out = c;
        last_out = c;
      end
      if (b_in_valid && b_in_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (int'(b_occ) > max_occ) max_occ = int'(b_occ);
      step();
    end
    chk("str_latency", 64'(first_out - first_acc), 64'd3);
    chk("str_thruput", 64'(last_out - first_out), 64'd7);
    chk("str_count",   64'(rcv.size()), 64'd8);
    for (int i = 0; i < 8 && i < rcv.size(); i++) chk("str_data", 64'(rcv[i]), 64'(i + 1));
    chk("str_max_occ", 64'(max_occ), 64'(OCC_ON ? 3 : 0));

    // ---- stream 1..6 with out_ready low in cycles 2..6
    do_reset();
    sent = 0;
    rcv.delete();
    for (int c = 0; c < 40; c++) begin
      b_out_ready = !(c >= 2 && c <= 6);
      b_in_valid  = (sent < 6);
      b_in_data   = 32'(sent + 1);
      #1;
      if (c >= 3 && c <= 6) begin
        chk("stall_in_ready", 64'(b_in_ready), 64'd0);
        chk("stall_out_vld",  64'(b_out_valid), 64'd1);
        chk("stall_out_data", 64'(b_out_data), 64'd1);
        chk("stall_occ",      64'(b_occ), 64'(OCC_ON ? 3 : 0));
      end
      if (b_out_valid && b_out_ready) rcv.push_back(b_out_data);
      if (b_in_valid && b_in_ready) sent++;
      step();
    end
    chk("stall_count", 64'(rcv.size()), 64'd6);
    for (int i = 0; i < 6 && i < rcv.size(); i++) chk("stall_data", 64'(rcv[i]), 64'(i + 1));

    // ---- full pipe, simultaneous in/out
    do_reset();
    b_in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      b_in_data = 32'hA + 32'(c);
      step();
    end
    b_in_data = 32'hD; b_out_ready = 1;
    #1;
    chk("full_in_ready",  64'(b_in_ready), 64'd1);
    chk("full_out_valid", 64'(b_out_valid), 64'd1);
    chk("full_out_data",  64'(b_out_data), 64'hA);
    step();
    chk("full_occ_keep", 64'(b_occ), 64'(OCC_ON ? 3 : 0));
    chk("full_next_data", 64'(b_out_data), 64'hB);

    // ---- flush full pipe with a beat offered
    b_flush = 1; b_in_valid = 1; b_in_data = 32'h55; b_out_ready = 0;
    #1;
    chk("flush_in_ready", 64'(b_in_ready), 64'd0);
    step();
    b_flush = 0; b_in_valid = 0; b_out_ready = 1;
    #1;
    chk("flush_occ",       64'(b_occ), 64'd0);
    chk("flush_out_valid", 64'(b_out_valid), 64'd0);
    chk("flush_in_ready2", 64'(b_in_ready), 64'd1);
    cyc = 0;
    for (int c = 0; c < 6; c++) begin
      if (b_out_valid) cyc++;
      step();
    end
    chk("flush_no_emit", 64'(cyc), 64'd0);

    // ---- async reset mid-transfer
    b_out_ready = 0; b_in_valid = 1; b_in_data = 32'h77;
    step(); step(); step();
    chk("pre_rst_full", 64'(b_out_valid), 64'd1);
    rst_n = 0;
    #1;
    chk("async_rst_vld",  64'(b_out_valid), 64'd0);
    chk("async_rst_data", 64'(b_out_data), 64'd0);
    chk("async_rst_occ",  64'(b_occ), 64'd0);
    rst_n = 1;
    idle_inputs();
    step();

    // ---- DEPTH=1, WIDTH=8: 0x00..0xFF with random out_ready
    do_reset();
    sent = 0;
    s_max_occ = 0;
    rcv.delete();
    for (int c = 0; c < 3000 && rcv.size() < 256; c++) begin
      s_out_ready = 1'($urandom_range(0, 1));
      s_in_valid  = (sent < 256);
      s_in_data   = 8'(sent);
      #1;
      if (s_out_valid && s_out_ready) rcv.push_back(32'(s_out_data));
      if (s_in_valid && s_in_ready) sent++;
      if (8'(s_occ) > s_max_occ) s_max_occ = 8'(s_occ);
      step();
    end
    chk("d1_count", 64'(rcv.size()), 64'd256);
    for (int i = 0; i < 256 && i < rcv.size(); i++) chk("d1_data", 64'(rcv[i]), 64'(i));
    chk("d1_max_occ", 64'(s_max_occ), 64'(OCC_ON ? 1 : 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
